vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_VIEW, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_VIEW, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BACK, 33, vertical back porch, in lines
- H_SYNC_POL, 0, active level of hsync
- V_SYNC_POL, 0, active level of vsync

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock
- reset_n, in, 1, asynchronous active-low reset
- en, in, 1, pixel advance enable
- x_px, out, 10, current column
- y_px, out, 10, current line
- activevideo, out, 1, high inside the visible area
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- frame_start, out, 1, one-cycle pulse on entry to position (0,0)
- frame_cnt, out, 8, frame counter

REQ-003 The block SHALL use one clock and an asynchronous active-low reset, reset_n; no other clock or reset exists.

REQ-004 The totals SHALL satisfy H_TOTAL = H_VIEW+H_FRONT+H_SYNC+H_BACK ≤ 1024 and V_TOTAL = V_VIEW+V_FRONT+V_SYNC+V_BACK ≤ 1024.

Function
REQ-005 Every output SHALL come directly from a flop, and all outputs in a given cycle SHALL describe the same (x_px, y_px) position, with zero skew between them.

REQ-006 The horizontal FSM SHALL have the states H_ACT, H_FP, H_SY and H_BP.
- Each state lasts exactly H_VIEW, H_FRONT, H_SYNC or H_BACK enabled cycles respectively.
- The states run in that order, and H_BP returns to H_ACT.

REQ-007 The vertical FSM SHALL have the states V_ACT, V_FP, V_SY and V_BP, lasting V_VIEW, V_FRONT, V_SYNC and V_BACK lines respectively; it advances only when x_px wraps.

REQ-008 On a cycle with en=1, x_px SHALL increment by 1. When x_px = H_TOTAL-1 it SHALL wrap to 0, and y_px SHALL then increment, wrapping from V_TOTAL-1 to 0.

REQ-009 On a cycle with en=0, every counter, FSM state and output SHALL hold its value, except frame_start, which SHALL be 0.

REQ-010 activevideo SHALL be 1 exactly when x_px < H_VIEW and y_px < V_VIEW.

REQ-011 hsync SHALL equal H_SYNC_POL exactly when H_VIEW+H_FRONT ≤ x_px < H_VIEW+H_FRONT+H_SYNC; otherwise it SHALL equal the inverse of H_SYNC_POL.

REQ-012 vsync SHALL equal V_SYNC_POL exactly when V_VIEW+V_FRONT ≤ y_px < V_VIEW+V_FRONT+V_SYNC, over whole lines; otherwise it SHALL equal the inverse of V_SYNC_POL.

REQ-013 frame_start SHALL be 1 for exactly one cycle: the cycle in which the outputs first present (0,0) after an enabled advance from (H_TOTAL-1, V_TOTAL-1). It SHALL NOT re-assert while en=0 holds the position.

REQ-014 Any parameter equal to 0 SHALL cause its FSM state to be skipped, without a dead cycle.

Reset
REQ-015 While reset_n=0, the block SHALL drive these values:
- x_px = H_TOTAL-1 and y_px = V_TOTAL-1
- activevideo = 0
- hsync = inverse of H_SYNC_POL, and vsync = inverse of V_SYNC_POL
- frame_start = 0 and frame_cnt = 0
- horizontal FSM in H_BP and vertical FSM in V_BP

REQ-016 Reset SHALL take effect immediately on assertion, including mid-line and mid-sync. The first enabled cycle after release SHALL present (0,0) with frame_start=1.

REQ-017 reset_n release SHALL be synchronised internally with a 2-flop deassertion synchroniser; assertion SHALL remain asynchronous.

Configuration
REQ-018 With the macro VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 in the same cycle that frame_start=1, wrapping from 255 to 0.

REQ-019 Without VGA_TIMING_FRAME_CNT_EN, the frame_cnt port SHALL still exist, SHALL be constant 0, and no counter flops SHALL be synthesised.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Default parameters, en=1, 2 frames → x_px period 800 clk; y_px period 420000 clk; hsync low for x=656..751; vsync low for lines 490..491; activevideo high for 307200 clk per frame.
- Reset release with en=1 → first cycle shows x=0, y=0, frame_start=1, activevideo=1; frame_start=0 on the next cycle.
- en=0 held for 5 cycles at x=655 → all outputs frozen, frame_start=0; hsync falls on the first enabled cycle after x=656 is reached.
- reset_n pulsed low at x=700, y=491 (both syncs active) → in the same cycle hsync=1, vsync=1, x=799, y=524, frame_cnt=0.
- With VGA_TIMING_FRAME_CNT_EN defined, 257 frames → frame_cnt counts 1..255, 0, 1. Without the macro → frame_cnt stays 0.
- H_FRONT=0, H_SYNC_POL=1 → hsync high starting at x=640, immediately after the last visible pixel; line period = 784.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters with horizontal and vertical phase FSMs.
// Every output is registered and all of them describe the same (x_px, y_px) position.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter;
// without it frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int unsigned H_VIEW     = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VIEW     = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned HTotal   = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal   = V_VIEW + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyStart = H_VIEW + H_FRONT;
  localparam int unsigned HBpStart = HSyStart + H_SYNC;
  localparam int unsigned VSyStart = V_VIEW + V_FRONT;
  localparam int unsigned VBpStart = VSyStart + V_SYNC;
  localparam logic [9:0]  XLast    = 10'(HTotal - 1);
  localparam logic [9:0]  YLast    = 10'(VTotal - 1);

  typedef enum logic [1:0] {HAct, HFp, HSy, HBp} h_state_e;
  typedef enum logic [1:0] {VAct, VFp, VSy, VBp} v_state_e;

  // Phase is chosen from the next position, so a zero-length phase is never entered.
  function automatic h_state_e h_region(input logic [9:0] pos);
    int unsigned p;
    p = 32'(pos);
    if (p < H_VIEW) return HAct;
    else if (p < HSyStart) return HFp;
    else if (p < HBpStart) return HSy;
    else return HBp;
  endfunction

  function automatic v_state_e v_region(input logic [9:0] pos);
    int unsigned p;
    p = 32'(pos);
    if (p < V_VIEW) return VAct;
    else if (p < VSyStart) return VFp;
    else if (p < VBpStart) return VSy;
    else return VBp;
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  logic [9:0] x_q, x_d, y_q, y_d;
  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic       activevideo_q, activevideo_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;

  // Reset synchroniser: assertion is immediate, release takes two clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Next position, FSM phases and the registered outputs that go with that position.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    frame_start_d = 1'b0;
    if (en) begin
      frame_start_d = (x_q == XLast) && (y_q == YLast);
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      h_state_d = h_region(x_d);
      // y_d only moves on a line wrap, so the vertical FSM only advances then.
      v_state_d = v_region(y_d);
    end
    activevideo_d = (h_state_d == HAct) && (v_state_d == VAct);
    hsync_d       = (h_state_d == HSy) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d       = (v_state_d == VSy) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  // State and output registers; reset parks the raster on the last pixel of the frame.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      x_q           <= XLast;
      y_q           <= YLast;
      h_state_q     <= HBp;
      v_state_q     <= VBp;
      activevideo_q <= 1'b0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      activevideo_q <= activevideo_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x_px        = x_q;
  assign y_px        = y_q;
  assign activevideo = activevideo_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Frame counter steps together with the frame_start pulse.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, small raster, H_FRONT=0 with
// positive hsync), a position model feeding an expected-value queue, and directed checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic en;

  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, s_x, s_y, f_x, f_y;
  logic       d_av, d_hs, d_vs, d_fs, s_av, s_hs, s_vs, s_fs, f_av, f_hs, f_vs, f_fs;
  logic [7:0] d_fc, s_fc, f_fc;

  vga_timing_gen u_def (
    .clk(clk), .reset_n(reset_n), .en(en), .x_px(d_x), .y_px(d_y), .activevideo(d_av),
    .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_VIEW(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VIEW(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .en(en), .x_px(s_x), .y_px(s_y), .activevideo(s_av),
    .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .H_FRONT(0), .H_SYNC_POL(1'b1)
  ) u_hf0 (
    .clk(clk), .reset_n(reset_n), .en(en), .x_px(f_x), .y_px(f_y), .activevideo(f_av),
    .hsync(f_hs), .vsync(f_vs), .frame_start(f_fs), .frame_cnt(f_fc)
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  bit frame_cnt_on = 1'b1;
`else
  bit frame_cnt_on = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model configuration and state.
  int  sel;
  int  p_hv, p_hf, p_hs, p_hb, p_vv, p_vf, p_vs, p_vb;
  bit  p_hp, p_vp;
  int  mx, my, mfc, sync_left;
  bit  in_reset;
  logic [31:0] exp_q[$];

  task automatic set_params(input int s, input int hv, input int hf, input int hs,
                            input int hb, input int vv, input int vf, input int vs,
                            input int vb, input bit hp, input bit vp);
    sel = s;
    p_hv = hv; p_hf = hf; p_hs = hs; p_hb = hb;
    p_vv = vv; p_vf = vf; p_vs = vs; p_vb = vb;
    p_hp = hp; p_vp = vp;
  endtask

  function automatic logic [31:0] pack_exp(input bit fs);
    logic av, hs, vs;
    av = (mx < p_hv) && (my < p_vv);
    hs = (mx >= p_hv + p_hf && mx < p_hv + p_hf + p_hs) ? p_hp : !p_hp;
    vs = (my >= p_vv + p_vf && my < p_vv + p_vf + p_vs) ? p_vp : !p_vp;
    return {10'(mx), 10'(my), av, hs, vs, fs, 8'(mfc)};
  endfunction

  function automatic logic [31:0] obs_now();
    case (sel)
      0:       return {d_x, d_y, d_av, d_hs, d_vs, d_fs, d_fc};
      1:       return {s_x, s_y, s_av, s_hs, s_vs, s_fs, s_fc};
      default: return {f_x, f_y, f_av, f_hs, f_vs, f_fs, f_fc};
    endcase
  endfunction

  // One clock: drive en, advance the model, queue expectation, compare at the negedge.
  task automatic tick(input bit e, input string tag);
    bit fs;
    int ht, vt;
    ht = p_hv + p_hf + p_hs + p_hb;
    vt = p_vv + p_vf + p_vs + p_vb;
    en = e;
    @(posedge clk);
    fs = 1'b0;
    if (in_reset) begin
      fs = 1'b0;
    end else if (sync_left > 0) begin
      sync_left--;
    end else if (e) begin
      fs = (mx == ht - 1) && (my == vt - 1);
      if (mx == ht - 1) begin
        mx = 0;
        my = (my == vt - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      if (fs && frame_cnt_on) mfc = (mfc + 1) % 256;
    end
    exp_q.push_back(pack_exp(fs));
    @(negedge clk);
    check(tag, obs_now(), exp_q.pop_front());
  endtask

  // Assert reset at the current (negedge) time and check it takes effect at once.
  task automatic do_reset(input string tag);
    en       = 1'b0;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    mx  = p_hv + p_hf + p_hs + p_hb - 1;
    my  = p_vv + p_vf + p_vs + p_vb - 1;
    mfc = 0;
    #1;
    check(tag, obs_now(), pack_exp(1'b0));
    tick(1'b0, "rst_hold");
    tick(1'b1, "rst_hold_en");
  endtask

  task automatic release_rst();
    reset_n   = 1'b1;
    in_reset  = 1'b0;
    sync_left = 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, first_x, fcount, av_n, cyc, fs_cyc;
    reset_n  = 1'b1;
    en       = 1'b0;
    in_reset = 1'b0;
    @(negedge clk);

    // Default timing: reset, release, en hold at x=655, line period, mid-line reset.
    set_params(0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    do_reset("def_reset");
    release_rst();
    tick(1'b1, "def_sync");
    tick(1'b1, "def_sync");
    tick(1'b1, "def_first");
    check("def_first_fs", {d_x, d_y, d_fs, d_av}, {10'd0, 10'd0, 1'b1, 1'b1});
    tick(1'b1, "def_second");
    check("def_second_fs", {31'd0, d_fs}, 32'd0);
    while (mx != 655) tick(1'b1, "def_run");
    repeat (5) tick(1'b0, "def_hold");
    tick(1'b1, "def_x656");
    check("def_hsync_656", {d_x, d_hs}, {10'd656, 1'b0});
    while (mx != 0) tick(1'b1, "def_run");
    n   = 0;
    cnt = 0;
    do begin
      tick(1'b1, "def_line");
      n++;
      if (d_hs == 1'b0) cnt++;
    end while (d_x != 10'd0 && n < 2000);
    check("def_line_period", n, 800);
    check("def_hsync_width", cnt, 96);
    while (mx != 700) tick(1'b1, "def_run");
    do_reset("def_midline_reset");

    // H_FRONT = 0 with active-high hsync: sync starts right after the last visible pixel.
    set_params(2, 640, 0, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0);
    do_reset("hf0_reset");
    release_rst();
    repeat (3) tick(1'b1, "hf0_start");
    n       = 0;
    cnt     = 0;
    first_x = -1;
    do begin
      tick(1'b1, "hf0_line");
      n++;
      if (f_hs == 1'b1) begin
        cnt++;
        if (first_x < 0) first_x = int'(f_x);
      end
    end while (f_x != 10'd0 && n < 2000);
    check("hf0_line_period", n, 784);
    check("hf0_hsync_width", cnt, 96);
    check("hf0_hsync_first_x", first_x, 640);

    // Small raster: 257 frames for frame_cnt, frame period, visible count, mid-sync reset.
    set_params(1, 8, 2, 3, 3, 4, 1, 2, 2, 1'b0, 1'b0);
    do_reset("small_reset");
    release_rst();
    tick(1'b1, "small_sync");
    tick(1'b1, "small_sync");
    fcount = 0;
    av_n   = 0;
    cyc    = 0;
    fs_cyc = 0;
    while (fcount < 257 && cyc < 50000) begin
      tick(1'b1, "small_frames");
      cyc++;
      if (s_fs) begin
        fcount++;
        if (fcount == 1) fs_cyc = cyc;
        if (fcount == 2) check("small_frame_period", cyc - fs_cyc, 144);
      end
      if (fcount == 1 && s_av) av_n++;
    end
    check("small_frame_count", fcount, 257);
    check("small_visible_cycles", av_n, 32);
    check("small_frame_cnt_final", {24'd0, s_fc}, frame_cnt_on ? 32'd1 : 32'd0);
    while (!(mx == 11 && my == 5)) tick(1'b1, "small_run");
    check("small_in_both_syncs", {30'd0, s_hs, s_vs}, 32'd0);
    do_reset("small_midsync_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
